vx_perf_memsys_ctrl: RTL and testbench
======================================

# vx_perf_memsys_ctrl

Readout controller for the memory-system performance counters: shares the 14 memsys counters carried on `VX_perf_memsys_if` between `NUM_REQS` requesters (CSR units, debug port) through a round-robin arbitrated request/response channel. It returns 32-bit halves of the counters. Reading the low half snapshots the whole counter per requester, so a lo-then-hi sequence is atomic even while counters advance. It sits between the memsys perf aggregation logic and the CSR read paths.

## Interface
- `NUM_REQS`, 2, number of requesters (1..8)
- `CTR_BITS`, `PERF_CTR_BITS` (44), counter width; must be 33..64
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `perf_memsys_if`  slave modport  14×`CTR_BITS`  live counter values
- `req_valid`  in  `NUM_REQS`  per-requester read request
- `req_idx`  in  `NUM_REQS`×4  counter index (0..13, package enum order)
- `req_hi`  in  `NUM_REQS`  0 = low 32 bits (snapshot), 1 = high bits from snapshot
- `req_ready`  out  `NUM_REQS`  one-hot grant; the request is accepted when `req_valid & req_ready`
- `rsp_valid`  out  1  response valid
- `rsp_data`  out  32  counter half
- `rsp_id`  out  clog2(`NUM_REQS`) (min 1)  requester that owns the response
- `rsp_err`  out  1  index out of range
- `rsp_ready`  in  1  response consumer ready

## Operation
- FSM `IDLE`/`RSP`. `IDLE`: the arbiter picks the first valid requester at or after `rr_ptr` and raises its `req_ready`. On accept, go to `RSP`.
- `RSP`: hold `rsp_*` stable while `rsp_ready`=0.
  - When `rsp_ready`=1, the response retires. In the same cycle the arbiter may grant a new request: stay in `RSP` if a grant occurs, else go to `IDLE`.
- `rr_ptr` moves to (granted+1) mod `NUM_REQS` on every accept. It does not move when there is no accept.
- Lo read (`req_hi`=0):
  - the selected counter is latched into `shadow[req]` (`CTR_BITS` wide);
  - `rsp_data` = counter[31:0], taken from the same-cycle value.
- Hi read (`req_hi`=1): `rsp_data` = zero-extended `shadow[req]`[`CTR_BITS`-1:32]. The live counter is not sampled.
- A hi read with no prior lo read returns the reset shadow value (0). This is legal and not an error.
- `req_idx` ≥ 14: `rsp_err`=1, `rsp_data`=0, shadow unchanged. The request is still consumed and answered.
- Each requester has its own shadow. A lo read by requester A does not disturb requester B's shadow.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `req_ready`=0 (registered-state derived), FSM=`IDLE`, `rr_ptr`=0, all shadows 0.
- `req_ready` is combinational from FSM state, `req_valid`, `rr_ptr` and `rsp_ready`. It never depends on `req_idx`/`req_hi`.
- Latency: accept in cycle N gives `rsp_valid` in cycle N+1.
  - With `rsp_ready` held high, throughput is 1 response per cycle.
- Backpressure: while `rsp_valid & !rsp_ready`, all `req_ready`=0 and `rsp_*` are frozen.
- Counter sampling happens in the accept cycle. Counter changes after acceptance do not affect the pending response.
- Simultaneous requests: exactly one grant per cycle. No requester starves; worst-case wait is `NUM_REQS`-1 grants.
- `reset_n` asserted mid-response: `rsp_valid` drops immediately (async). The in-flight response is lost and all state returns to reset values.
- Requesters must hold `req_valid`/`req_idx`/`req_hi` until accepted. Withdrawal before accept is tolerated and causes no response.

## Structure
- Package `vx_perf_memsys_pkg`:
  - `NUM_MEMSYS_CTRS`=14;
  - enum `memsys_ctr_e` in order: icache_reads, icache_read_misses, dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses, dcache_bank_stalls, dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls, mem_reads, mem_writes, mem_latency;
  - FSM state typedef.
- Sub-module `vx_perf_rr_arbiter`:
  - parameterised `NUM_REQS`;
  - inputs `requests`, `enable`;
  - outputs one-hot `grant` and encoded `grant_idx`;
  - owns `rr_ptr`, which advances only when `enable & |requests`.
- Top level holds the counter mux, the shadow array, the FSM and the response registers.

## Test plan
- Single lo read: dcache_reads=0x0A_1234_5678, req0 idx=2 hi=0 → next cycle `rsp_data`=0x12345678, `rsp_id`=0, `rsp_err`=0.
- Atomic pair: mem_latency=0x0FF_FFFF_FFFF at the lo read, then it increments to 0x100_0000_0000 before the hi read → lo=0xFFFFFFFF, hi=0x000000FF (shadow, not live 0x100).
- Fairness: both requesters hold valid continuously with `rsp_ready`=1 → `rsp_id` alternates 0,1,0,1… with one response per cycle.
- Backpressure: `rsp_ready`=0 for 5 cycles with new valid requests pending → `rsp_*` stable, `req_ready`=0. The cycle after `rsp_ready`=1, the next response appears.
- Error/idx: req1 idx=15 → `rsp_err`=1, `rsp_data`=0; a following req1 hi read returns the previous shadow unchanged.
- Reset mid-op: assert `reset_n`=0 while `rsp_valid`=1 and `rsp_ready`=0 → `rsp_valid`=0 without a clock edge. After release, a hi read returns 0 and the first grant goes to requester 0.

Source files
------------

// File: rtl/vx_perf_memsys_pkg.sv
// Shared types and sizes for the memory-system performance counter readout.
package vx_perf_memsys_pkg;

   localparam int PERF_CTR_BITS   = 44;
   localparam int NUM_MEMSYS_CTRS = 14;
   localparam int CTR_IDX_W       = 4;

   typedef enum logic [CTR_IDX_W-1:0] {
      CTR_ICACHE_READS        = 4'd0,
      CTR_ICACHE_READ_MISSES  = 4'd1,
      CTR_DCACHE_READS        = 4'd2,
      CTR_DCACHE_WRITES       = 4'd3,
      CTR_DCACHE_READ_MISSES  = 4'd4,
      CTR_DCACHE_WRITE_MISSES = 4'd5,
      CTR_DCACHE_BANK_STALLS  = 4'd6,
      CTR_DCACHE_MSHR_STALLS  = 4'd7,
      CTR_SMEM_READS          = 4'd8,
      CTR_SMEM_WRITES         = 4'd9,
      CTR_SMEM_BANK_STALLS    = 4'd10,
      CTR_MEM_READS           = 4'd11,
      CTR_MEM_WRITES          = 4'd12,
      CTR_MEM_LATENCY         = 4'd13
   } memsys_ctr_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RSP  = 1'b1
   } rd_state_e;

   function automatic logic ctr_idx_ok(input logic [CTR_IDX_W-1:0] idx);
      return idx < CTR_IDX_W'(NUM_MEMSYS_CTRS);
   endfunction

endpackage

// File: rtl/vx_perf_memsys_if.sv
// Live memsys counter bundle driven by the perf aggregation logic.
interface VX_perf_memsys_if #(
   parameter int CTR_BITS = vx_perf_memsys_pkg::PERF_CTR_BITS
);
   logic [CTR_BITS-1:0] icache_reads;
   logic [CTR_BITS-1:0] icache_read_misses;
   logic [CTR_BITS-1:0] dcache_reads;
   logic [CTR_BITS-1:0] dcache_writes;
   logic [CTR_BITS-1:0] dcache_read_misses;
   logic [CTR_BITS-1:0] dcache_write_misses;
   logic [CTR_BITS-1:0] dcache_bank_stalls;
   logic [CTR_BITS-1:0] dcache_mshr_stalls;
   logic [CTR_BITS-1:0] smem_reads;
   logic [CTR_BITS-1:0] smem_writes;
   logic [CTR_BITS-1:0] smem_bank_stalls;
   logic [CTR_BITS-1:0] mem_reads;
   logic [CTR_BITS-1:0] mem_writes;
   logic [CTR_BITS-1:0] mem_latency;

   modport master (
      output icache_reads, icache_read_misses, dcache_reads, dcache_writes,
             dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
             dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
             mem_reads, mem_writes, mem_latency
   );

   modport slave (
      input icache_reads, icache_read_misses, dcache_reads, dcache_writes,
            dcache_read_misses, dcache_write_misses, dcache_bank_stalls,
            dcache_mshr_stalls, smem_reads, smem_writes, smem_bank_stalls,
            mem_reads, mem_writes, mem_latency
   );

endinterface

// File: rtl/vx_perf_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after rr_ptr; the
// pointer moves past the winner only when the grant is actually taken.
module vx_perf_rr_arbiter #(
   parameter  int NUM_REQS = 2,
   localparam int ID_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic [NUM_REQS-1:0] requests_i,
   input  logic                enable_i,
   output logic [NUM_REQS-1:0] grant_o,
   output logic [ID_W-1:0]     grant_idx_o
);

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W:0]   pos;
   logic [ID_W-1:0] pos_idx;
   logic            found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      pos         = '0;
      pos_idx     = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         pos = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (pos >= (ID_W+1)'(NUM_REQS)) pos = pos - (ID_W+1)'(NUM_REQS);
         pos_idx = pos[ID_W-1:0];
         if (!found && requests_i[pos_idx]) begin
            found            = 1'b1;
            grant_o[pos_idx] = 1'b1;
            grant_idx_o      = pos_idx;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (enable_i && |requests_i) begin
         rr_ptr_d = (int'(grant_idx_o) == NUM_REQS-1) ? '0 : grant_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rr_ptr_q <= '0;
      else            rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/vx_perf_memsys_ctrl.sv
// Arbitrated readout of memsys perf counters in 32-bit halves; a lo read
// snapshots the full counter per requester so the following hi read is atomic.
module vx_perf_memsys_ctrl
   import vx_perf_memsys_pkg::*;
#(
   parameter  int NUM_REQS = 2,
   parameter  int CTR_BITS = PERF_CTR_BITS,
   localparam int ID_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   VX_perf_memsys_if.slave                    perf_memsys_if,
   input  logic [NUM_REQS-1:0]                req_valid_i,
   input  logic [NUM_REQS-1:0][CTR_IDX_W-1:0] req_idx_i,
   input  logic [NUM_REQS-1:0]                req_hi_i,
   output logic [NUM_REQS-1:0]                req_ready_o,
   output logic                               rsp_valid_o,
   output logic [31:0]                        rsp_data_o,
   output logic [ID_W-1:0]                    rsp_id_o,
   output logic                               rsp_err_o,
   input  logic                               rsp_ready_i
);

   rd_state_e                         state_q;
   logic [NUM_REQS-1:0][CTR_BITS-1:0] shadow_q;
   logic [CTR_BITS-1:0]               ctrs [2**CTR_IDX_W];

   logic                 arb_en;
   logic                 accept;
   logic [NUM_REQS-1:0]  grant;
   logic [ID_W-1:0]      gidx;
   logic [CTR_IDX_W-1:0] sel_idx;
   logic                 sel_hi;
   logic                 sel_ok;
   logic [CTR_BITS-1:0]  sel_ctr;
   logic [31:0]          rsp_data_d;

   // Indices 14/15 land on zero entries; they are flagged as errors anyway.
   always_comb begin
      ctrs                          = '{default: '0};
      ctrs[CTR_ICACHE_READS]        = perf_memsys_if.icache_reads;
      ctrs[CTR_ICACHE_READ_MISSES]  = perf_memsys_if.icache_read_misses;
      ctrs[CTR_DCACHE_READS]        = perf_memsys_if.dcache_reads;
      ctrs[CTR_DCACHE_WRITES]       = perf_memsys_if.dcache_writes;
      ctrs[CTR_DCACHE_READ_MISSES]  = perf_memsys_if.dcache_read_misses;
      ctrs[CTR_DCACHE_WRITE_MISSES] = perf_memsys_if.dcache_write_misses;
      ctrs[CTR_DCACHE_BANK_STALLS]  = perf_memsys_if.dcache_bank_stalls;
      ctrs[CTR_DCACHE_MSHR_STALLS]  = perf_memsys_if.dcache_mshr_stalls;
      ctrs[CTR_SMEM_READS]          = perf_memsys_if.smem_reads;
      ctrs[CTR_SMEM_WRITES]         = perf_memsys_if.smem_writes;
      ctrs[CTR_SMEM_BANK_STALLS]    = perf_memsys_if.smem_bank_stalls;
      ctrs[CTR_MEM_READS]           = perf_memsys_if.mem_reads;
      ctrs[CTR_MEM_WRITES]          = perf_memsys_if.mem_writes;
      ctrs[CTR_MEM_LATENCY]         = perf_memsys_if.mem_latency;
   end

   // A new grant is possible when idle or when the pending response retires.
   assign arb_en = (state_q == ST_IDLE) || rsp_ready_i;

   vx_perf_rr_arbiter #(
      .NUM_REQS (NUM_REQS)
   ) u_arb (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .requests_i  (req_valid_i),
      .enable_i    (arb_en),
      .grant_o     (grant),
      .grant_idx_o (gidx)
   );

   assign req_ready_o = arb_en ? grant : '0;
   assign accept      = arb_en && |req_valid_i;

   assign sel_idx = req_idx_i[gidx];
   assign sel_hi  = req_hi_i[gidx];
   assign sel_ok  = ctr_idx_ok(sel_idx);
   assign sel_ctr = ctrs[sel_idx];

   always_comb begin
      rsp_data_d = '0;
      if (sel_ok) begin
         rsp_data_d = sel_hi ? 32'(shadow_q[gidx][CTR_BITS-1:32]) : sel_ctr[31:0];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         shadow_q <= '0;
      end else if (accept && sel_ok && !sel_hi) begin
         shadow_q[gidx] <= sel_ctr;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_id_o    <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q     <= ST_RSP;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= rsp_data_d;
                  rsp_id_o    <= gidx;
                  rsp_err_o   <= !sel_ok;
               end
            end
            ST_RSP: begin
               if (accept) begin
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= rsp_data_d;
                  rsp_id_o    <= gidx;
                  rsp_err_o   <= !sel_ok;
               end else if (rsp_ready_i) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_o <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               rsp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vx_perf_memsys_ctrl.sv
// Bench for vx_perf_memsys_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_vx_perf_memsys_ctrl;

   localparam int NR = 2;
   localparam int CB = 44;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0][3:0] req_idx = '0;
   logic [NR-1:0]   req_hi = '0;
   logic [NR-1:0]   req_ready;
   logic            rsp_valid;
   logic [31:0]     rsp_data;
   logic [0:0]      rsp_id;
   logic            rsp_err;
   logic            rsp_ready = 1'b1;
   logic [CB-1:0]   ctr [14];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   VX_perf_memsys_if #(.CTR_BITS(CB)) mif ();
   assign mif.icache_reads        = ctr[0];
   assign mif.icache_read_misses  = ctr[1];
   assign mif.dcache_reads        = ctr[2];
   assign mif.dcache_writes       = ctr[3];
   assign mif.dcache_read_misses  = ctr[4];
   assign mif.dcache_write_misses = ctr[5];
   assign mif.dcache_bank_stalls  = ctr[6];
   assign mif.dcache_mshr_stalls  = ctr[7];
   assign mif.smem_reads          = ctr[8];
   assign mif.smem_writes         = ctr[9];
   assign mif.smem_bank_stalls    = ctr[10];
   assign mif.mem_reads           = ctr[11];
   assign mif.mem_writes          = ctr[12];
   assign mif.mem_latency         = ctr[13];

   vx_perf_memsys_ctrl #(.NUM_REQS(NR), .CTR_BITS(CB)) dut (
      .clk_i          (clk),
      .reset_n_i      (reset_n),
      .perf_memsys_if (mif),
      .req_valid_i    (req_valid),
      .req_idx_i      (req_idx),
      .req_hi_i       (req_hi),
      .req_ready_o    (req_ready),
      .rsp_valid_o    (rsp_valid),
      .rsp_data_o     (rsp_data),
      .rsp_id_o       (rsp_id),
      .rsp_err_o      (rsp_err),
      .rsp_ready_i    (rsp_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [CB-1:0] m_shadow [NR];
   int            m_rr;
   bit            m_pv;
   logic [31:0]   m_data;
   int            m_id;
   bit            m_err;

   function automatic int m_pick();
      for (int k = 0; k < NR; k++) begin
         if (req_valid[(m_rr + k) % NR]) return (m_rr + k) % NR;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] m_ready();
      logic [NR-1:0] r;
      int g;
      r = '0;
      g = m_pick();
      if ((!m_pv || rsp_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NR; r++) m_shadow[r] = '0;
         m_rr = 0; m_pv = 0; m_data = 0; m_id = 0; m_err = 0;
      end else begin
         int g;
         int ix;
         g = m_pick();
         if ((!m_pv || rsp_ready) && g >= 0) begin
            ix     = int'(req_idx[g]);
            m_pv   = 1;
            m_id   = g;
            m_err  = (ix >= 14);
            if (ix >= 14)      m_data = 0;
            else if (req_hi[g]) m_data = 32'(m_shadow[g] >> 32);
            else begin
               m_data      = ctr[ix][31:0];
               m_shadow[g] = ctr[ix];
            end
            m_rr = (g + 1) % NR;
         end else if (rsp_ready) begin
            m_pv = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("req_ready", 64'(req_ready), 64'(m_ready()));
         chk("rsp_valid", 64'(rsp_valid), 64'(m_pv));
         if (m_pv) begin
            chk("rsp_data", 64'(rsp_data), 64'(m_data));
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_err", 64'(rsp_err), 64'(m_err));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic rd(input int r, input int idx, input bit hi,
                     output logic [31:0] d, output logic e, output int id);
      bit ok;
      @(posedge clk); #1;
      req_valid[r] = 1'b1; req_idx[r] = 4'(idx); req_hi[r] = hi;
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (req_ready[r]) ok = 1;
      end
      if (!ok) chk("accept_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      @(negedge clk);
      chk("rsp_latency_valid", 64'(rsp_valid), 64'(1));
      d = rsp_data; e = rsp_err; id = int'(rsp_id);
   endtask

   logic [31:0] d;
   logic        e;
   int          id;
   logic [NR-1:0] acc;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 14; i++) ctr[i] = CB'(i * 4096 + 7);

      // reset values
      #12;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rsp_data", 64'(rsp_data), 64'(0));
      chk("reset_rsp_id", 64'(rsp_id), 64'(0));
      chk("reset_rsp_err", 64'(rsp_err), 64'(0));
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      @(negedge clk); reset_n = 1'b1;

      // single lo read
      ctr[2] = 44'h0A_1234_5678;
      rd(0, 2, 0, d, e, id);
      chk("lo_data", 64'(d), 64'h12345678);
      chk("lo_id", 64'(id), 64'(0));
      chk("lo_err", 64'(e), 64'(0));

      // atomic lo/hi pair across a carry into bit 40
      ctr[13] = 44'h0FF_FFFF_FFFF;
      rd(0, 13, 0, d, e, id);
      chk("atomic_lo", 64'(d), 64'hFFFFFFFF);
      ctr[13] = 44'h100_0000_0000;
      rd(0, 13, 1, d, e, id);
      chk("atomic_hi", 64'(d), 64'h000000FF);

      // out-of-range index leaves the shadow intact; shadows are per requester
      ctr[5] = 44'hABC_1234_5678;
      rd(1, 5, 0, d, e, id);
      chk("r1_lo", 64'(d), 64'h12345678);
      chk("r1_lo_id", 64'(id), 64'(1));
      rd(1, 15, 0, d, e, id);
      chk("err_flag", 64'(e), 64'(1));
      chk("err_data", 64'(d), 64'(0));
      rd(1, 0, 1, d, e, id);
      chk("err_shadow_kept", 64'(d), 64'hABC);
      chk("err_shadow_noerr", 64'(e), 64'(0));
      rd(0, 3, 1, d, e, id);
      chk("r0_shadow_isolated", 64'(d), 64'hFF);

      // fairness: rr pointer now at 1, both requesters held valid
      @(posedge clk); #1;
      req_valid = 2'b11; req_idx[0] = 4'd1; req_idx[1] = 4'd2; req_hi = 2'b00;
      @(negedge clk);
      chk("fair_first_grant", 64'(req_ready), 64'(2'b10));
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("fair_valid", 64'(rsp_valid), 64'(1));
         chk("fair_id", 64'(rsp_id), 64'(k % 2));
      end

      // backpressure with requests pending
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_ready_low", 64'(req_ready), 64'(0));
         chk("bp_valid_held", 64'(rsp_valid), 64'(1));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_grant", 64'($countones(req_ready)), 64'(1));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("bp_next_rsp", 64'(rsp_valid), 64'(1));
      @(negedge clk);

      // randomized traffic
      acc = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk); #1;
         for (int r = 0; r < NR; r++) begin
            if (!req_valid[r] || acc[r]) begin
               req_valid[r] = ($urandom_range(0, 2) != 0);
               req_idx[r]   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(14, 15))
                                                          : 4'($urandom_range(0, 13));
               req_hi[r]    = $urandom_range(0, 1) == 1;
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[r] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 31) == 0) ctr[i] = CB'({$urandom, $urandom});
            else ctr[i] = ctr[i] + CB'($urandom_range(0, 3));
         end
      end
      @(posedge clk); #1;
      req_valid = '0; rsp_ready = 1'b1;
      @(negedge clk); @(negedge clk);

      // async reset while a response is stalled
      @(posedge clk); #1;
      rsp_ready = 1'b0; req_valid[1] = 1'b1; req_idx[1] = 4'd2; req_hi[1] = 1'b0;
      @(negedge clk);
      chk("rst_pre_grant", 64'(req_ready), 64'(2'b10));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("rst_pre_valid", 64'(rsp_valid), 64'(1));
      #2 reset_n = 1'b0;
      #1 chk("rst_async_drop", 64'(rsp_valid), 64'(0));
      @(negedge clk);
      reset_n = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 2'b11; req_idx[0] = 4'd13; req_idx[1] = 4'd2; req_hi = 2'b11;
      @(negedge clk);
      chk("rst_first_grant", 64'(req_ready), 64'(2'b01));
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("rst_hi_r0_data", 64'(rsp_data), 64'(0));
      chk("rst_hi_r0_id", 64'(rsp_id), 64'(0));
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("rst_hi_r1_data", 64'(rsp_data), 64'(0));
      chk("rst_hi_r1_id", 64'(rsp_id), 64'(1));
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
